bus_arbiter_rr: RTL and testbench

- Round-robin arbiter for the shared address/data bus used by the DMA controller and the other bus masters (CPU, display, camera).
- Sits directly upstream of each master's transactionGranted input: collects request lines, grants one master at a time and holds the grant for the whole burst.
- Watchdog terminates stalled transactions with an arbiter-driven bus error plus end-of-transaction, so a hung slave cannot lock the bus.

---
 rtl/bus_arbiter_rr.sv | 146 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: one-hot registered grant held for a whole burst,
// with begin and idle watchdogs so a silent master or hung slave cannot lock the bus.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int IDLE_TIMEOUT  = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   dataValidIn,
  input  logic                   busErrorIn,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [2:0]             grantedId,
  output logic                   busActive,
  output logic                   busErrorOut,
  output logic                   endTransactionOut
);

  localparam int BEGIN_W = $clog2(BEGIN_TIMEOUT + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BEGIN_W-1:0] BEGIN_LAST = BEGIN_W'(BEGIN_TIMEOUT - 1);
  localparam logic [BEGIN_W-1:0] BEGIN_MAX  = '1;
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE, ABORT} state_t;

  state_t                 state, state_next;
  logic [2:0]             last_id, last_next;
  logic [BEGIN_W-1:0]     begin_cnt, begin_next;
  logic [IDLE_W-1:0]      idle_cnt, idle_next;
  logic [NUM_MASTERS-1:0] grant_next, sel_grant;
  logic [2:0]             id_next, sel_id;
  logic                   active_next, err_next, end_next;
  logic                   sel_found, owner_req;

  // A slave error on its own changes nothing; the arbiter waits for the end.
  logic unused_bus_error;
  assign unused_bus_error = busErrorIn;

  assign owner_req = |(grant & request);

  // Scan from lastId+1 upwards; descending offsets so the nearest one wins last.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_grant = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (request[j] && (((int'(last_id) + k) % NUM_MASTERS) == j)) begin
          sel_found    = 1'b1;
          sel_id       = 3'(j);
          sel_grant    = '0;
          sel_grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    id_next     = grantedId;
    active_next = busActive;
    err_next    = 1'b0;
    end_next    = 1'b0;
    last_next   = last_id;
    begin_next  = begin_cnt;
    idle_next   = idle_cnt;
    case (state)
      IDLE: begin
        grant_next  = '0;
        active_next = 1'b0;
        if (sel_found) begin
          state_next  = GRANTED;
          grant_next  = sel_grant;
          id_next     = sel_id;
          last_next   = sel_id;
          active_next = 1'b1;
          begin_next  = '0;
        end
      end
      GRANTED: begin
        if (beginTransactionIn) begin
          state_next = ACTIVE;
          idle_next  = '0;
        end else if (!owner_req || begin_cnt == BEGIN_LAST) begin
          state_next  = IDLE;
          grant_next  = '0;
          active_next = 1'b0;
        end else begin
          begin_next = (begin_cnt == BEGIN_MAX) ? begin_cnt : begin_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (endTransactionIn) begin
          state_next  = IDLE;
          grant_next  = '0;
          active_next = 1'b0;
        end else if (dataValidIn) begin
          idle_next = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_next = ABORT;
          err_next   = 1'b1;
          end_next   = 1'b1;
        end else begin
          idle_next = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
        end
      end
      ABORT: begin
        state_next  = IDLE;
        grant_next  = '0;
        active_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      grant             <= '0;
      grantedId         <= '0;
      busActive         <= 1'b0;
      busErrorOut       <= 1'b0;
      endTransactionOut <= 1'b0;
      last_id           <= 3'(NUM_MASTERS - 1);
      begin_cnt         <= '0;
      idle_cnt          <= '0;
    end else begin
      state             <= state_next;
      grant             <= grant_next;
      grantedId         <= id_next;
      busActive         <= active_next;
      busErrorOut       <= err_next;
      endTransactionOut <= end_next;
      last_id           <= last_next;
      begin_cnt         <= begin_next;
      idle_cnt          <= idle_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr with hand-computed expectations.
module tb_bus_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic       beginTransactionIn, endTransactionIn, dataValidIn, busErrorIn;
  logic [3:0] grant;
  logic [2:0] grantedId;
  logic       busActive, busErrorOut, endTransactionOut;

  int errorCount = 0;
  int checkCount = 0;

  bus_arbiter_rr #(.NUM_MASTERS(4), .BEGIN_TIMEOUT(16), .IDLE_TIMEOUT(256)) dut (
    .clock             (clock),
    .reset             (reset),
    .request           (request),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .dataValidIn       (dataValidIn),
    .busErrorIn        (busErrorIn),
    .grant             (grant),
    .grantedId         (grantedId),
    .busActive         (busActive),
    .busErrorOut       (busErrorOut),
    .endTransactionOut (endTransactionOut)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic beg, input logic en,
                               input logic dv, input logic err);
    request            = req;
    beginTransactionIn = beg;
    endTransactionIn   = en;
    dataValidIn        = dv;
    busErrorIn         = err;
  endtask

  task automatic stepCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    stepCycle(1);
    reset = 1'b0;
  endtask

  logic [3:0] expGrant;
  logic       sawPulse;

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("reset_grant", grant, 4'b0000);
    checkOutput("reset_active", busActive, 1'b0);
    checkOutput("reset_err", busErrorOut, 1'b0);
    checkOutput("reset_end", endTransactionOut, 1'b0);
    checkOutput("reset_id", grantedId, 3'd0);
    reset = 1'b0;

    // Single master, full transaction
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("t1_grant", grant, 4'b0010);
    checkOutput("t1_id", grantedId, 3'd1);
    checkOutput("t1_active", busActive, 1'b1);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle(1);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle(1);
    checkOutput("t1_errin_grant", grant, 4'b0010);
    checkOutput("t1_errin_errout", busErrorOut, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(4);
    checkOutput("t1_held_grant", grant, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("t1_end_grant", grant, 4'b0000);
    checkOutput("t1_end_active", busActive, 1'b0);

    // All masters requesting: rotation 0,1,2,3,0 with an idle gap each time
    doReset();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle(1);
      expGrant = 4'b0001 << (n % 4);
      checkOutput("rr_grant", grant, expGrant);
      checkOutput("rr_id", grantedId, 3'(n % 4));
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCycle(1);
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle(1);
      applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle(1);
      checkOutput("rr_gap_grant", grant, 4'b0000);
    end

    // Master 2 never begins: withdrawn after 16 cycles, master 3 next
    doReset();
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("bto_grant", grant, 4'b0100);
    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    sawPulse = 1'b0;
    for (int c = 0; c < 15; c++) begin
      stepCycle(1);
      sawPulse |= busErrorOut | endTransactionOut;
    end
    checkOutput("bto_still_held", grant, 4'b0100);
    stepCycle(1);
    sawPulse |= busErrorOut | endTransactionOut;
    checkOutput("bto_withdrawn", grant, 4'b0000);
    checkOutput("bto_no_err", sawPulse, 1'b0);
    stepCycle(1);
    checkOutput("bto_next_grant", grant, 4'b1000);
    checkOutput("bto_next_id", grantedId, 3'd3);

    // Master 3 begins then goes silent: abort after 256 idle cycles
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    sawPulse = 1'b0;
    for (int c = 0; c < 255; c++) begin
      stepCycle(1);
      sawPulse |= busErrorOut | endTransactionOut;
    end
    checkOutput("wd_no_early", sawPulse, 1'b0);
    checkOutput("wd_held", grant, 4'b1000);
    stepCycle(1);
    checkOutput("wd_err", busErrorOut, 1'b1);
    checkOutput("wd_end", endTransactionOut, 1'b1);
    checkOutput("wd_grant_during", grant, 4'b1000);
    stepCycle(1);
    checkOutput("wd_err_off", busErrorOut, 1'b0);
    checkOutput("wd_end_off", endTransactionOut, 1'b0);
    checkOutput("wd_grant_off", grant, 4'b0000);
    checkOutput("wd_active_off", busActive, 1'b0);

    // dataValid every 200 cycles keeps the watchdog quiet
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("dv_grant", grant, 4'b0001);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    sawPulse = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0, (c % 200) == 0, 1'b0);
      stepCycle(1);
      sawPulse |= busErrorOut | endTransactionOut;
    end
    checkOutput("dv_no_abort", sawPulse, 1'b0);
    checkOutput("dv_held", grant, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("dv_release", grant, 4'b0000);
    checkOutput("dv_active_off", busActive, 1'b0);

    // Async reset mid-burst, then lastId restored to the top index
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    checkOutput("ar_grant", grant, 4'b0010);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(2);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("ar_grant_low", grant, 4'b0000);
    checkOutput("ar_active_low", busActive, 1'b0);
    checkOutput("ar_err_low", busErrorOut, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle(1);
    reset = 1'b0;
    stepCycle(1);
    checkOutput("ar_after_grant", grant, 4'b0001);
    checkOutput("ar_after_id", grantedId, 3'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
